// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - 8N1 UART transmitter with a small holding FIFO
// Optional even-parity bit between data and stop when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int TERM_COUNT = CLK_FREQ / BAUD;
  localparam int CW = (TERM_COUNT > 1) ? $clog2(TERM_COUNT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(TERM_COUNT - 1);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_done;
  logic            r_overrun;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
`ifdef SERIAL_TX_PARITY_EN
  logic            r_parity;
`endif

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_bit_end;
  logic [7:0]      w_head;

  // Full is taken from the registered count, so a write in the same cycle as a pop still drops.
  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = tx_write && !w_full;
  assign w_bit_end = (r_cnt == '0);
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk100) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (tx_write && w_full) r_overrun <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The line register follows the state one clock later, so every bit is TERM_COUNT clocks wide.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_cnt   <= RELOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_cnt     <= RELOAD;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_cnt     <= RELOAD;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_parity;
          if (w_bit_end) begin
            r_cnt   <= RELOAD;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_done <= 1'b1;
            if (w_pop) begin
              r_shift <= w_head;
`ifdef SERIAL_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_cnt   <= RELOAD;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign tx_done    = r_done;
  assign tx_overrun = r_overrun;
  assign tx_full    = w_full;
  assign tx_busy    = (r_state != S_IDLE) || !w_empty;

endmodule
